// File: rtl/bank_state_resp.sv
// Purpose: per-bank DDR state tracker; checks each decoded command against the bank FSMs/timers and answers with a status.
// Latency: 1 cycle, all outputs registered; rsp_valid pulses the cycle after any non-NOP command.
// Backpressure: none, one command per cycle always accepted; optional tRAS check via macro DDR_BANK_TRAS_CHK_EN.
module bank_state_resp #(
    parameter int NUMBER_BANK = 16,
    parameter int RA_WIDTH    = 15,
    parameter int T_RCD       = 11,
    parameter int T_RP        = 11,
    parameter int T_RAS       = 28
) (
    input  logic                   clock_t,
    input  logic                   reset_n,
    input  logic                   cmd_valid,
    input  logic [2:0]             cmd_type,
    input  logic [3:0]             cmd_bank,
    input  logic [RA_WIDTH-1:0]    cmd_row,
    output logic                   rsp_valid,
    output logic [2:0]             rsp_err,
    output logic [RA_WIDTH-1:0]    rsp_row,
    output logic                   rsp_rw,
    output logic [NUMBER_BANK-1:0] bank_open
);
    typedef enum logic [1:0] {ST_IDLE, ST_ACTIVATING, ST_ACTIVE, ST_PRECHARGING} bank_st_t;

    localparam logic [2:0] CMD_NOP  = 3'd0;
    localparam logic [2:0] CMD_ACT  = 3'd1;
    localparam logic [2:0] CMD_PRE  = 3'd2;
    localparam logic [2:0] CMD_PREA = 3'd3;
    localparam logic [2:0] CMD_RD   = 3'd4;
    localparam logic [2:0] CMD_WR   = 3'd5;

    localparam logic [2:0] ERR_OK         = 3'd0;
    localparam logic [2:0] ERR_ACT_BUSY   = 3'd1;
    localparam logic [2:0] ERR_CAS_CLOSED = 3'd2;
    localparam logic [2:0] ERR_CAS_EARLY  = 3'd3;
    localparam logic [2:0] ERR_ACT_EARLY  = 3'd4;
    localparam logic [2:0] ERR_PRE_EARLY  = 3'd5;
    localparam logic [2:0] ERR_ILLEGAL    = 3'd6;

    // Timers are wide enough for the largest timing parameter, never below 6 bits
    localparam int TMR_MAX = (T_RCD > T_RP) ? ((T_RCD > T_RAS) ? T_RCD : T_RAS)
                                            : ((T_RP > T_RAS) ? T_RP : T_RAS);
    localparam int TMR_W   = ($clog2(TMR_MAX + 1) > 6) ? $clog2(TMR_MAX + 1) : 6;
    localparam logic [TMR_W-1:0] TMR_ONE = TMR_W'(1);
    localparam logic [TMR_W-1:0] RCD_LD  = TMR_W'(T_RCD);
    localparam logic [TMR_W-1:0] RP_LD   = TMR_W'(T_RP);

    bank_st_t            st_q  [NUMBER_BANK];
    bank_st_t            st_x  [NUMBER_BANK];
    bank_st_t            st_d  [NUMBER_BANK];
    logic [TMR_W-1:0]    tmr_q [NUMBER_BANK];
    logic [TMR_W-1:0]    tmr_x [NUMBER_BANK];
    logic [TMR_W-1:0]    tmr_d [NUMBER_BANK];
    logic [RA_WIDTH-1:0] row_q [NUMBER_BANK];
    logic [RA_WIDTH-1:0] row_d [NUMBER_BANK];
`ifdef DDR_BANK_TRAS_CHK_EN
    localparam logic [TMR_W-1:0] RAS_LD = TMR_W'(T_RAS);
    logic [TMR_W-1:0]    ras_q [NUMBER_BANK];
    logic [TMR_W-1:0]    ras_x [NUMBER_BANK];
    logic [TMR_W-1:0]    ras_d [NUMBER_BANK];
`endif
    logic [NUMBER_BANK-1:0] ras_ok;   // an ACTIVE bank may be precharged

    logic                   sel_hit;
    bank_st_t               sel_st;
    logic [RA_WIDTH-1:0]    sel_row;
    logic                   sel_ras_ok;
    logic                   any_activating;
    logic                   any_ras_block;
    logic                   rsp_valid_d;
    logic [2:0]             rsp_err_d;
    logic [RA_WIDTH-1:0]    rsp_row_d;
    logic                   rsp_rw_d;
    logic [NUMBER_BANK-1:0] bank_open_d;

    // Timer tick and expiry: a finishing ACT/PRE resolves before the command of this cycle is judged
    always_comb begin
        for (int i = 0; i < NUMBER_BANK; i++) begin
            st_x[i]  = st_q[i];
            tmr_x[i] = (tmr_q[i] != '0) ? tmr_q[i] - TMR_ONE : '0;
            if (tmr_q[i] <= TMR_ONE) begin
                if (st_q[i] == ST_ACTIVATING)  st_x[i] = ST_ACTIVE;
                if (st_q[i] == ST_PRECHARGING) st_x[i] = ST_IDLE;
            end
`ifdef DDR_BANK_TRAS_CHK_EN
            ras_x[i]  = (ras_q[i] != '0) ? ras_q[i] - TMR_ONE : '0;
            ras_ok[i] = (ras_q[i] <= TMR_ONE);
`else
            ras_ok[i] = 1'b1;
`endif
        end
    end

    // Command evaluation against the post-expiry view; only accepted commands modify bank state
    always_comb begin
        sel_hit        = 1'b0;
        sel_st         = ST_IDLE;
        sel_row        = '0;
        sel_ras_ok     = 1'b0;
        any_activating = 1'b0;
        any_ras_block  = 1'b0;
        for (int i = 0; i < NUMBER_BANK; i++) begin
            if (int'(cmd_bank) == i) begin
                sel_hit    = 1'b1;
                sel_st     = st_x[i];
                sel_row    = row_q[i];
                sel_ras_ok = ras_ok[i];
            end
            if (st_x[i] == ST_ACTIVATING)             any_activating = 1'b1;
            if (st_x[i] == ST_ACTIVE && !ras_ok[i])    any_ras_block  = 1'b1;
        end

        st_d  = st_x;
        tmr_d = tmr_x;
        row_d = row_q;
`ifdef DDR_BANK_TRAS_CHK_EN
        ras_d = ras_x;
`endif
        rsp_valid_d = 1'b0;
        rsp_err_d   = ERR_OK;
        rsp_row_d   = '0;
        rsp_rw_d    = 1'b0;

        if (cmd_valid && cmd_type != CMD_NOP) begin
            rsp_valid_d = 1'b1;
            case (cmd_type)
                CMD_ACT: begin
                    // a bank index beyond NUMBER_BANK has no tracker and is refused
                    if (!sel_hit)                         rsp_err_d = ERR_ILLEGAL;
                    else if (sel_st == ST_PRECHARGING)    rsp_err_d = ERR_ACT_EARLY;
                    else if (sel_st != ST_IDLE)           rsp_err_d = ERR_ACT_BUSY;
                    else begin
                        for (int i = 0; i < NUMBER_BANK; i++) begin
                            if (int'(cmd_bank) == i) begin
                                st_d[i]  = ST_ACTIVATING;
                                tmr_d[i] = RCD_LD;
                                row_d[i] = cmd_row;
`ifdef DDR_BANK_TRAS_CHK_EN
                                ras_d[i] = RAS_LD;
`endif
                            end
                        end
                    end
                end
                CMD_PRE: begin
                    if (!sel_hit) rsp_err_d = ERR_ILLEGAL;
                    else if (sel_st == ST_ACTIVATING || (sel_st == ST_ACTIVE && !sel_ras_ok))
                        rsp_err_d = ERR_PRE_EARLY;
                    else if (sel_st == ST_ACTIVE) begin
                        for (int i = 0; i < NUMBER_BANK; i++) begin
                            if (int'(cmd_bank) == i) begin
                                st_d[i]  = ST_PRECHARGING;
                                tmr_d[i] = RP_LD;
                            end
                        end
                    end
                    // IDLE / PRECHARGING: harmless no-op, timer keeps running
                end
                CMD_PREA: begin
                    if (any_activating || any_ras_block) rsp_err_d = ERR_PRE_EARLY;
                    else begin
                        for (int i = 0; i < NUMBER_BANK; i++) begin
                            if (st_x[i] == ST_ACTIVE) begin
                                st_d[i]  = ST_PRECHARGING;
                                tmr_d[i] = RP_LD;
                            end
                        end
                    end
                end
                CMD_RD, CMD_WR: begin
                    if (!sel_hit)                       rsp_err_d = ERR_ILLEGAL;
                    else if (sel_st == ST_ACTIVATING)   rsp_err_d = ERR_CAS_EARLY;
                    else if (sel_st != ST_ACTIVE)       rsp_err_d = ERR_CAS_CLOSED;
                    else begin
                        rsp_row_d = sel_row;
                        rsp_rw_d  = (cmd_type == CMD_WR);
                    end
                end
                default: rsp_err_d = ERR_ILLEGAL;
            endcase
        end

        for (int i = 0; i < NUMBER_BANK; i++)
            bank_open_d[i] = (st_d[i] == ST_ACTIVATING) || (st_d[i] == ST_ACTIVE);
    end

    // State and response registers; reset clears every bank and aborts all timers
    always_ff @(posedge clock_t) begin
        if (!reset_n) begin
            for (int i = 0; i < NUMBER_BANK; i++) begin
                st_q[i]  <= ST_IDLE;
                tmr_q[i] <= '0;
                row_q[i] <= '0;
`ifdef DDR_BANK_TRAS_CHK_EN
                ras_q[i] <= '0;
`endif
            end
            rsp_valid <= 1'b0;
            rsp_err   <= ERR_OK;
            rsp_row   <= '0;
            rsp_rw    <= 1'b0;
            bank_open <= '0;
        end else begin
            for (int i = 0; i < NUMBER_BANK; i++) begin
                st_q[i]  <= st_d[i];
                tmr_q[i] <= tmr_d[i];
                row_q[i] <= row_d[i];
`ifdef DDR_BANK_TRAS_CHK_EN
                ras_q[i] <= ras_d[i];
`endif
            end
            rsp_valid <= rsp_valid_d;
            rsp_err   <= rsp_err_d;
            rsp_row   <= rsp_row_d;
            rsp_rw    <= rsp_rw_d;
            bank_open <= bank_open_d;
        end
    end
endmodule

// File: tb/tb_bank_state_resp.sv
// Purpose: directed bench for bank_state_resp with a response scoreboard.
// Latency: expects each response one cycle after its command; bank_open checked just after the sampling edge.
// Backpressure: none; DUT accepts one command per cycle.
module tb_bank_state_resp;
    localparam int RA = 15;
    localparam int NB = 16;

    localparam logic [2:0] NOP = 3'd0, ACT = 3'd1, PRE = 3'd2, PREA = 3'd3, RD = 3'd4, WR = 3'd5;
    localparam logic [2:0] E_OK = 3'd0, E_BUSY = 3'd1, E_CLOSED = 3'd2, E_CAS_EARLY = 3'd3;
    localparam logic [2:0] E_ACT_EARLY = 3'd4, E_PRE_EARLY = 3'd5, E_ILLEGAL = 3'd6;

    logic          clock_t   = 1'b0;
    logic          reset_n   = 1'b0;
    logic          cmd_valid = 1'b0;
    logic [2:0]    cmd_type  = 3'd0;
    logic [3:0]    cmd_bank  = 4'd0;
    logic [RA-1:0] cmd_row   = '0;
    logic          rsp_valid;
    logic [2:0]    rsp_err;
    logic [RA-1:0] rsp_row;
    logic          rsp_rw;
    logic [NB-1:0] bank_open;

    bank_state_resp #(
        .NUMBER_BANK(NB), .RA_WIDTH(RA), .T_RCD(11), .T_RP(11), .T_RAS(28)
    ) dut (
        .clock_t(clock_t), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_type(cmd_type),
        .cmd_bank(cmd_bank), .cmd_row(cmd_row), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
        .rsp_row(rsp_row), .rsp_rw(rsp_rw), .bank_open(bank_open)
    );

    always #5 clock_t = ~clock_t;

    int cyc = 0;
    always @(posedge clock_t) cyc <= cyc + 1;

    typedef struct {
        int            due;
        logic          vld;
        logic [2:0]    err;
        logic [RA-1:0] row;
        logic          rw;
        logic          rw_chk;
        string         tag;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    logic rst_lvl  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Drive one cycle of stimulus at the falling edge and queue what must come back
    task automatic drive(input string tag, input logic v, input logic [2:0] t, input logic [3:0] b,
                         input logic [RA-1:0] r, input logic ev, input logic [2:0] ee,
                         input logic [RA-1:0] er, input logic ew);
        exp_t e;
        @(negedge clock_t);
        reset_n   = rst_lvl;
        cmd_valid = v;
        cmd_type  = t;
        cmd_bank  = b;
        cmd_row   = r;
        e.due     = cyc + 1;
        e.vld     = ev;
        e.err     = ee;
        e.row     = er;
        e.rw      = ew;
        e.rw_chk  = ev && (t == RD || t == WR) && (ee == E_OK);
        e.tag     = tag;
        sb.push_back(e);
    endtask

    task automatic cmd(input string tag, input logic [2:0] t, input logic [3:0] b, input logic [RA-1:0] r,
                       input logic [2:0] ee, input logic [RA-1:0] er, input logic ew);
        drive(tag, 1'b1, t, b, r, 1'b1, ee, er, ew);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive("idle", 1'b0, NOP, 4'd0, '0, 1'b0, E_OK, '0, 1'b0);
    endtask

    task automatic open_chk(input string tag, input logic [NB-1:0] exp);
        @(posedge clock_t);
        #1;
        chk(tag, 32'(bank_open), 32'(exp));
    endtask

    // Scoreboard: pop every expectation that falls due this cycle and compare with the outputs
    always @(negedge clock_t) begin : mon
        exp_t e;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            chk({e.tag, ".vld"}, 32'(rsp_valid), 32'(e.vld));
            if (e.vld) begin
                chk({e.tag, ".err"}, 32'(rsp_err), 32'(e.err));
                chk({e.tag, ".row"}, 32'(rsp_row), 32'(e.row));
                if (e.rw_chk) chk({e.tag, ".rw"}, 32'(rsp_rw), 32'(e.rw));
            end
        end
    end

    initial begin
        // reset: a command presented under reset gets no response
        rst_lvl = 1'b0;
        drive("act_in_rst", 1'b1, ACT, 4'd2, 15'h0011, 1'b0, E_OK, '0, 1'b0);
        idle(2);
        @(posedge clock_t);
        #1;
        chk("rst.vld", 32'(rsp_valid), 32'd0);
        chk("rst.err", 32'(rsp_err), 32'd0);
        chk("rst.row", 32'(rsp_row), 32'd0);
        chk("rst.rw", 32'(rsp_rw), 32'd0);
        chk("rst.open", 32'(bank_open), 32'd0);
        rst_lvl = 1'b1;

        // ACT then RD exactly tRCD later
        cmd("act3", ACT, 4'd3, 15'h1A2B, E_OK, '0, 1'b0);
        open_chk("open3", 16'h0008);
        idle(10);
        cmd("rd3", RD, 4'd3, '0, E_OK, 15'h1A2B, 1'b0);

        // WR one cycle before tRCD is early, retry on the boundary is OK
        cmd("act0", ACT, 4'd0, 15'h0055, E_OK, '0, 1'b0);
        idle(9);
        cmd("wr0_early", WR, 4'd0, '0, E_CAS_EARLY, '0, 1'b0);
        cmd("wr0", WR, 4'd0, '0, E_OK, 15'h0055, 1'b1);

        // assorted rejections and no-ops
        cmd("rd6_closed", RD, 4'd6, '0, E_CLOSED, '0, 1'b0);
        cmd("pre6_noop", PRE, 4'd6, '0, E_OK, '0, 1'b0);
        cmd("act3_busy", ACT, 4'd3, 15'h7777, E_BUSY, '0, 1'b0);
        cmd("act8", ACT, 4'd8, 15'h0808, E_OK, '0, 1'b0);
        cmd("act8_busy", ACT, 4'd8, 15'h0999, E_BUSY, '0, 1'b0);
        cmd("rd8_early", RD, 4'd8, '0, E_CAS_EARLY, '0, 1'b0);
        cmd("pre8_early", PRE, 4'd8, '0, E_PRE_EARLY, '0, 1'b0);
        open_chk("open_038", 16'h0109);
        drive("nv_act10", 1'b0, ACT, 4'd10, 15'h0010, 1'b0, E_OK, '0, 1'b0);
        cmd("rd10_closed", RD, 4'd10, '0, E_CLOSED, '0, 1'b0);
        cmd("rd3_row_kept", RD, 4'd3, '0, E_OK, 15'h1A2B, 1'b0);

        // PRE then ACT around tRP; a PRE to a precharging bank must not restart its timer
        cmd("act5", ACT, 4'd5, 15'h0AAA, E_OK, '0, 1'b0);
        idle(10);
        cmd("rd5", RD, 4'd5, '0, E_OK, 15'h0AAA, 1'b0);
        idle(17);
        cmd("pre5", PRE, 4'd5, '0, E_OK, '0, 1'b0);
        open_chk("open5_clr", 16'h0109);
        idle(8);
        cmd("pre5_noop", PRE, 4'd5, '0, E_OK, '0, 1'b0);
        cmd("act5_early", ACT, 4'd5, 15'h0BBB, E_ACT_EARLY, '0, 1'b0);
        cmd("act5_again", ACT, 4'd5, 15'h0BBB, E_OK, '0, 1'b0);
        open_chk("open5_set", 16'h0129);
        idle(10);
        cmd("rd5_new_row", RD, 4'd5, '0, E_OK, 15'h0BBB, 1'b0);

        // PREA is refused while any bank is still activating
        cmd("act1", ACT, 4'd1, 15'h0101, E_OK, '0, 1'b0);
        cmd("act2", ACT, 4'd2, 15'h0202, E_OK, '0, 1'b0);
        idle(27);
        cmd("act7", ACT, 4'd7, 15'h0707, E_OK, '0, 1'b0);
        cmd("prea_early", PREA, 4'd0, '0, E_PRE_EARLY, '0, 1'b0);
        open_chk("open_prea_rej", 16'h01AF);
        idle(8);
        cmd("prea_edge", PREA, 4'd0, '0, E_PRE_EARLY, '0, 1'b0);
`ifdef DDR_BANK_TRAS_CHK_EN
        cmd("prea_ras", PREA, 4'd0, '0, E_PRE_EARLY, '0, 1'b0);
        idle(15);
        cmd("prea_ras_edge", PREA, 4'd0, '0, E_PRE_EARLY, '0, 1'b0);
`endif
        cmd("prea", PREA, 4'd0, '0, E_OK, '0, 1'b0);
        open_chk("open_prea", 16'h0000);
        cmd("rd1_closed", RD, 4'd1, '0, E_CLOSED, '0, 1'b0);
        cmd("act1_early", ACT, 4'd1, 15'h0111, E_ACT_EARLY, '0, 1'b0);
        idle(12);

        // PRE one cycle before tRAS
        cmd("act9", ACT, 4'd9, 15'h0009, E_OK, '0, 1'b0);
        idle(26);
`ifdef DDR_BANK_TRAS_CHK_EN
        cmd("pre9_early", PRE, 4'd9, '0, E_PRE_EARLY, '0, 1'b0);
`else
        cmd("pre9", PRE, 4'd9, '0, E_OK, '0, 1'b0);
`endif
        cmd("pre9_b", PRE, 4'd9, '0, E_OK, '0, 1'b0);
        open_chk("open9", 16'h0000);

        // reset in the middle of an activation
        cmd("act4", ACT, 4'd4, 15'h0444, E_OK, '0, 1'b0);
        idle(4);
        rst_lvl = 1'b0;
        drive("rd4_in_rst", 1'b1, RD, 4'd4, '0, 1'b0, E_OK, '0, 1'b0);
        open_chk("open_rst", 16'h0000);
        idle(1);
        rst_lvl = 1'b1;
        idle(1);
        cmd("rd4_closed", RD, 4'd4, '0, E_CLOSED, '0, 1'b0);
        cmd("ill7", 3'd7, 4'd4, '0, E_ILLEGAL, '0, 1'b0);
        cmd("ill6", 3'd6, 4'd0, '0, E_ILLEGAL, '0, 1'b0);
        idle(8);
        cmd("rd4_still_closed", RD, 4'd4, '0, E_CLOSED, '0, 1'b0);

        idle(3);
        @(negedge clock_t);
        #1;
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/bank_state_resp.md
BANK_STATE_RESP -- requirements
Module: bank_state_resp

Interface
REQ-001 Parameter NUMBER_BANK, default 16: banks tracked, indexed by {bg,ba}.
REQ-002 Parameter RA_WIDTH, default 15: row address width.
REQ-003 Parameter T_RCD, default 11: clocks from ACT to first legal RD/WR on that bank.
REQ-004 Parameter T_RP, default 11: clocks from PRE to next legal ACT on that bank.
REQ-005 Parameter T_RAS, default 28: clocks from ACT to first legal PRE on that bank (used only when the REQ-033 macro is defined).
REQ-006 clock_t  in  1  single clock; all state updates on its rising edge.
REQ-007 reset_n  in  1  reset; synchronous and active-low.
REQ-008 cmd_valid  in  1  decoded command present this cycle.
REQ-009 cmd_type  in  3  0 NOP, 1 ACT, 2 PRE, 3 PREA, 4 RD, 5 WR; 6-7 reserved.
REQ-010 cmd_bank  in  4  target bank {bg,ba}; ignored for PREA.
REQ-011 cmd_row  in  RA_WIDTH  row address; used only for ACT.
REQ-012 rsp_valid  out  1  one-cycle pulse; response to the command accepted on the previous cycle.
REQ-013 rsp_err  out  3  0 OK, 1 ACT_BUSY, 2 CAS_CLOSED, 3 CAS_EARLY, 4 ACT_EARLY, 5 PRE_EARLY, 6 ILLEGAL.
REQ-014 rsp_row  out  RA_WIDTH  open row of the addressed bank, valid with an OK RD/WR response; 0 otherwise.
REQ-015 rsp_rw  out  1  1 = WR, 0 = RD; valid with an OK RD/WR response.
REQ-016 bank_open  out  NUMBER_BANK  bit i = 1 while bank i is ACTIVATING or ACTIVE.

Function
REQ-017 Each bank has a 4-state FSM: IDLE, ACTIVATING, ACTIVE, PRECHARGING, plus a timer (at least 6 bits) and a RA_WIDTH row register.
REQ-018 ACT to an IDLE bank at cycle N: state becomes ACTIVATING and the row is latched; the bank becomes ACTIVE so that RD/WR is legal from cycle N+T_RCD.
REQ-019 PRE to an ACTIVE bank at cycle N: state becomes PRECHARGING; the bank becomes IDLE so that ACT is legal from cycle N+T_RP.
REQ-020 PRE to an IDLE or PRECHARGING bank is a legal no-op: response OK, no timer restart.
REQ-021 PRE to an ACTIVATING bank: PRE_EARLY, no state change.
REQ-022 PREA: every ACTIVE bank goes to PRECHARGING. If any bank is ACTIVATING, the whole PREA is rejected with PRE_EARLY and no bank changes.
REQ-023 ACT to an ACTIVATING or ACTIVE bank: ACT_BUSY. ACT to a PRECHARGING bank: ACT_EARLY.
REQ-024 RD/WR to an IDLE or PRECHARGING bank: CAS_CLOSED. RD/WR to an ACTIVATING bank: CAS_EARLY.
REQ-025 RD/WR to an ACTIVE bank: OK, with rsp_row equal to the latched row and rsp_rw set; bank state is unchanged.
REQ-026 Reserved cmd_type: ILLEGAL. NOP, or cmd_valid=0, produces no response (rsp_valid=0).
REQ-027 A rejected command never changes any bank state or timer.
REQ-028 Latency: all outputs are registered; rsp_valid asserts exactly 1 cycle after a non-NOP command. bank_open reflects state after the same edge.
REQ-029 One command per cycle. A timer expiry and a new command to the same bank in the same cycle: expiry applies first, then the command is evaluated against the post-expiry state.
REQ-030 Timers saturate at 0; no wrap-around.

Reset
REQ-031 While reset_n=0 at a clock_t edge: all banks IDLE, timers 0, rows 0, rsp_valid 0, rsp_err 0, rsp_row 0, rsp_rw 0, bank_open all 0.
REQ-032 A reset asserted mid-operation aborts all timers at that edge. No response is issued for a command presented in the reset cycle.

Configuration
REQ-033 Macro DDR_BANK_TRAS_CHK_EN:
- Defined: each bank keeps a second timer loaded with T_RAS on ACT. PRE or PREA to an ACTIVE bank before N+T_RAS returns PRE_EARLY with no state change; a rejected PREA changes no bank.
- Undefined: no tRAS timer is implemented, and a PRE to an ACTIVE bank is always accepted.

Verification
REQ-034 Reset, then ACT bank 3 row 0x1A2B at cycle 10, RD bank 3 at cycle 21 -> cycle 11 rsp OK, bank_open[3]=1; cycle 22 rsp OK, rsp_row=0x1A2B, rsp_rw=0.
REQ-035 ACT bank 0 at cycle 10, WR bank 0 at cycle 20 -> CAS_EARLY at cycle 21; a retry WR at cycle 21 -> OK at cycle 22.
REQ-036 Bank 5 ACTIVE, PRE at cycle 100, ACT at cycle 110 -> ACT_EARLY; ACT at cycle 111 -> OK, bank_open[5]=1.
REQ-037 Banks 1 and 2 ACTIVE, bank 7 ACTIVATING, PREA -> PRE_EARLY, bank_open bits 1, 2 and 7 remain 1; PREA after bank 7 reaches ACTIVE -> OK, all three bits clear.
REQ-038 With DDR_BANK_TRAS_CHK_EN defined, ACT bank 9 at cycle 0, PRE at cycle 27 -> PRE_EARLY, PRE at cycle 28 -> OK. Without the macro, PRE at cycle 27 -> OK.
REQ-039 Reset asserted at cycle 15 while bank 4 is ACTIVATING, released at cycle 17 -> bank_open=0 at cycle 16; RD bank 4 at cycle 18 -> CAS_CLOSED; cmd_type 7 -> ILLEGAL.
